ysyx_22040632_trap_ctrl: RTL and testbench
==========================================

# ysyx_22040632_trap_ctrl

Trap sequencer at the EX stage. It consumes the level-sensitive machine-timer interrupt from the core-local timer, together with ecall/mret from the instruction in EX. It stalls EX, updates mepc/mcause/mstatus through single-cycle CSR write strobes, then flushes the pipeline and redirects fetch. For interrupt traps it returns a one-cycle acknowledge to the timer so the timer drops its request.

## Interface
Parameters:
- XLEN, 64, data/CSR width; PC is also XLEN wide.
- TIMER_CAUSE, 7, exception code for the machine-timer interrupt.
- ECALL_CAUSE, 11, exception code for ecall from M-mode.

Ports:
- clk  in  1  clock, all state on rising edge.
- rrst  in  1  asynchronous reset, active-high.
- intrrupt_timing2ex  in  1  timer interrupt request, level, held until acknowledged.
- intrrupt_ack2clint  out  1  one-cycle acknowledge to the timer.
- ex_valid_i  in  1  EX holds a real instruction.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- ex_ecall_i, ex_mret_i  in  1 each  EX instruction is ecall / mret.
- ex_stall_o  out  1  hold EX, suppress commit of the EX instruction.
- mstatus_i, mepc_i, mtvec_i  in  XLEN each  current CSR values.
- csr_we_mepc_o, csr_we_mcause_o, csr_we_mstatus_o  out  1 each  write strobes.
- csr_mepc_o, csr_mcause_o, csr_mstatus_o  out  XLEN each  write data.
- flush_o  out  1  kill IF/ID/EX contents.
- redirect_valid_o  out  1  fetch must load redirect_pc_o.
- redirect_pc_o  out  XLEN  new fetch PC.

## Operation
- FSM states: IDLE, SAVE, JUMP. Reset state is IDLE.
- IDLE, with event = ex_valid_i && (intrrupt_timing2ex || ex_ecall_i || ex_mret_i):
  - Priority is interrupt > ecall > mret.
  - ex_stall_o is driven combinationally high in the same cycle.
  - The block captures kind (IRQ/ECALL/MRET), ex_pc_i and the cause, then moves to SAVE.
- SAVE: one cycle with ex_stall_o=1.
  - IRQ or ECALL:
    - csr_mepc_o = captured PC. For ECALL this is the ecall's own PC; software adds 4.
    - csr_mcause_o = {1'b1, TIMER_CAUSE} for IRQ, {1'b0, ECALL_CAUSE} for ECALL. The cause sits in bit XLEN-1 and the low bits, zero-extended.
    - csr_mstatus_o = mstatus_i with MPIE := MIE, MIE := 0, MPP := 2'b11.
    - All three write strobes are 1.
  - MRET:
    - csr_mstatus_o = mstatus_i with MIE := MPIE, MPIE := 1, MPP := 2'b11.
    - Only csr_we_mstatus_o is 1.
  - Next state is JUMP.
- JUMP: one cycle with flush_o=1 and redirect_valid_o=1.
  - redirect_pc_o = captured mepc_i for MRET (sampled in SAVE), otherwise {mtvec_i[XLEN-1:2], 2'b00}.
  - intrrupt_ack2clint=1 only for kind IRQ.
  - ex_stall_o=0. Next state is IDLE.
- Events arriving in SAVE/JUMP are ignored. The interrupt level persists, so a pending interrupt is re-evaluated in IDLE after redirect.
- The captured kind is final: the interrupt deasserting after capture does not abort the sequence, and the ack still pulses.
- ex_valid_i=0 in IDLE means no trap is taken, even with the interrupt high.

## Timing
- Reset values: all outputs 0, redirect_pc_o=0, captured registers 0, FSM in IDLE.
- Assertion of rrst in any state returns to IDLE immediately; any in-flight trap is dropped with no strobes.
- Latency: event seen in cycle N → CSR strobes in N+1 → redirect/flush/ack in N+2 → IDLE accepts a new event in N+3.
- Strobes, flush, redirect and ack are single-cycle pulses, registered outputs. Only ex_stall_o has a combinational IDLE term.
- A back-to-back interrupt needs the CSR file to have cleared MIE in N+1. Gating by MIE/MTIE is the timer's job; this block does not re-check it.

## Configuration
- YSYX_22040632_VECTORED_MTVEC_EN, when defined:
  - If mtvec_i[1:0]==2'b01 and kind is IRQ, redirect_pc_o = base + 4*TIMER_CAUSE, i.e. base+0x1C.
  - ECALL and MRET are unaffected.
- When undefined, mtvec_i[1:0] is ignored and every trap goes to base.

## Structure
- Shared package ysyx_22040632_riscv_pkg.svh holds:
  - the trap_kind_e enum (IRQ, ECALL, MRET);
  - the trap_state_e enum (IDLE, SAVE, JUMP);
  - mstatus bit-position constants (MIE=3, MPIE=7, MPP=12:11);
  - the cause codes.
- One sub-module: ysyx_22040632_mstatus_upd, combinational. It takes mstatus_i and the kind and produces the trap-entry or mret mstatus value.

## Test plan
- Reset, then interrupt=1, ex_valid=1, ex_pc=0x80000100, mtvec=0x80000000, mstatus=0x8 → N: stall; N+1: mepc=0x80000100, mcause=0x8000000000000007, mstatus=0x1880; N+2: flush, redirect=0x80000000, ack=1.
- ecall at 0x80000200, no interrupt → mcause=11, mepc=0x80000200, ack stays 0 throughout.
- Interrupt and ecall in the same cycle → IRQ taken (mcause bit63=1); ecall instruction not committed.
- mret with mstatus=0x1880, mepc=0x80000104 → only the mstatus strobe, data=0x1888; redirect=0x80000104, ack=0.
- rrst asserted during SAVE → all outputs 0 the same cycle; no redirect follows; next interrupt is handled normally.
- With YSYX_22040632_VECTORED_MTVEC_EN and mtvec=0x80000001: IRQ redirect=0x8000001C, ecall redirect=0x80000000.

Source files
------------

// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared trap definitions: trap kinds, sequencer states, mstatus bit positions
// and the machine cause codes used by the trap controller.
package ysyx_22040632_riscv_pkg;

  // Zero encodes IRQ so the cleared capture register is a legal kind.
  typedef enum logic [1:0] {
    KindIrq   = 2'd0,
    KindEcall = 2'd1,
    KindMret  = 2'd2
  } trap_kind_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSave = 2'd1,
    StJump = 2'd2
  } trap_state_e;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  localparam int unsigned TimerCause = 7;
  localparam int unsigned EcallCause = 11;

endpackage

// File: rtl/ysyx_22040632_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (IRQ/ECALL) and for mret.
module ysyx_22040632_mstatus_upd
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  trap_kind_e      kind_i,
  output logic [XLEN-1:0] mstatus_o
);

  // Entry stacks MIE into MPIE; mret pops it back. MPP always reads M-mode.
  always_comb begin
    mstatus_o = mstatus_i;
    if (kind_i == KindMret) begin
      mstatus_o[MstatusMie]  = mstatus_i[MstatusMpie];
      mstatus_o[MstatusMpie] = 1'b1;
    end else begin
      mstatus_o[MstatusMpie] = mstatus_i[MstatusMie];
      mstatus_o[MstatusMie]  = 1'b0;
    end
    mstatus_o[MstatusMppHi:MstatusMppLo] = 2'b11;
  end

endmodule

// File: rtl/ysyx_22040632_trap_ctrl.sv
// EX-stage trap sequencer: IDLE -> SAVE (CSR strobes) -> JUMP (flush/redirect/ack).
// Optional feature: YSYX_22040632_VECTORED_MTVEC_EN enables vectored mtvec for
// the timer interrupt (base + 4*TIMER_CAUSE when mtvec mode is 2'b01).
module ysyx_22040632_trap_ctrl
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TIMER_CAUSE = TimerCause,
  parameter int unsigned ECALL_CAUSE = EcallCause
) (
  input  logic            clk,
  input  logic            rrst,
  input  logic            intrrupt_timing2ex,
  output logic            intrrupt_ack2clint,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_ecall_i,
  input  logic            ex_mret_i,
  output logic            ex_stall_o,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            csr_we_mepc_o,
  output logic            csr_we_mcause_o,
  output logic            csr_we_mstatus_o,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic [XLEN-1:0] csr_mstatus_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  trap_state_e     r_state, w_state_d;
  trap_kind_e      r_kind, w_kind_sel;
  logic [XLEN-1:0] r_pc;
  logic            w_event;
  logic [XLEN-1:0] w_mstatus_new;
  logic [XLEN-1:0] w_trap_base;
  logic [XLEN-1:0] w_trap_target;

  // Next values of the registered outputs.
  logic            w_we_mepc_d, w_we_mcause_d, w_we_mstatus_d;
  logic [XLEN-1:0] w_mepc_d, w_mcause_d, w_mstatus_d;
  logic            w_flush_d, w_redirect_valid_d, w_ack_d;
  logic [XLEN-1:0] w_redirect_pc_d;

  assign w_event     = ex_valid_i && (intrrupt_timing2ex || ex_ecall_i || ex_mret_i);
  assign w_trap_base = {mtvec_i[XLEN-1:2], 2'b00};

  // Priority select of the trap kind: interrupt > ecall > mret.
  always_comb begin
    if (intrrupt_timing2ex)  w_kind_sel = KindIrq;
    else if (ex_ecall_i)     w_kind_sel = KindEcall;
    else                     w_kind_sel = KindMret;
  end

`ifdef YSYX_22040632_VECTORED_MTVEC_EN
  // Vectored mode only redirects the timer interrupt; ecall/mret use the base.
  always_comb begin
    if ((mtvec_i[1:0] == 2'b01) && (r_kind == KindIrq)) begin
      w_trap_target = w_trap_base + XLEN'(4 * TIMER_CAUSE);
    end else begin
      w_trap_target = w_trap_base;
    end
  end
`else
  logic [1:0] w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = mtvec_i[1:0];
  assign w_trap_target       = w_trap_base;
`endif

  ysyx_22040632_mstatus_upd #(
    .XLEN (XLEN)
  ) u_mstatus_upd (
    .mstatus_i (mstatus_i),
    .kind_i    (w_kind_sel),
    .mstatus_o (w_mstatus_new)
  );

  // State register.
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  // Next-state logic; events outside IDLE are ignored.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_event) w_state_d = StSave;
      StSave:  w_state_d = StJump;
      StJump:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Capture the trap kind and PC when the event is accepted.
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      r_kind <= KindIrq;
      r_pc   <= '0;
    end else if ((r_state == StIdle) && w_event) begin
      r_kind <= w_kind_sel;
      r_pc   <= ex_pc_i;
    end
  end

  // Output next-values: SAVE pulses are prepared in IDLE, JUMP pulses in SAVE.
  always_comb begin
    w_we_mepc_d        = 1'b0;
    w_we_mcause_d      = 1'b0;
    w_we_mstatus_d     = 1'b0;
    w_mepc_d           = '0;
    w_mcause_d         = '0;
    w_mstatus_d        = '0;
    w_flush_d          = 1'b0;
    w_redirect_valid_d = 1'b0;
    w_redirect_pc_d    = '0;
    w_ack_d            = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_event) begin
          w_we_mstatus_d = 1'b1;
          w_mstatus_d    = w_mstatus_new;
          unique case (w_kind_sel)
            KindIrq: begin
              w_we_mepc_d   = 1'b1;
              w_we_mcause_d = 1'b1;
              w_mepc_d      = ex_pc_i;
              w_mcause_d    = {1'b1, (XLEN-1)'(TIMER_CAUSE)};
            end
            KindEcall: begin
              w_we_mepc_d   = 1'b1;
              w_we_mcause_d = 1'b1;
              w_mepc_d      = ex_pc_i;
              w_mcause_d    = {1'b0, (XLEN-1)'(ECALL_CAUSE)};
            end
            default: ;
          endcase
        end
      end
      StSave: begin
        w_flush_d          = 1'b1;
        w_redirect_valid_d = 1'b1;
        w_ack_d            = (r_kind == KindIrq);
        w_redirect_pc_d    = (r_kind == KindMret) ? mepc_i : w_trap_target;
      end
      default: ;
    endcase
  end

  // Registered pulse outputs.
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      csr_we_mepc_o      <= 1'b0;
      csr_we_mcause_o    <= 1'b0;
      csr_we_mstatus_o   <= 1'b0;
      csr_mepc_o         <= '0;
      csr_mcause_o       <= '0;
      csr_mstatus_o      <= '0;
      flush_o            <= 1'b0;
      redirect_valid_o   <= 1'b0;
      redirect_pc_o      <= '0;
      intrrupt_ack2clint <= 1'b0;
    end else begin
      csr_we_mepc_o      <= w_we_mepc_d;
      csr_we_mcause_o    <= w_we_mcause_d;
      csr_we_mstatus_o   <= w_we_mstatus_d;
      csr_mepc_o         <= w_mepc_d;
      csr_mcause_o       <= w_mcause_d;
      csr_mstatus_o      <= w_mstatus_d;
      flush_o            <= w_flush_d;
      redirect_valid_o   <= w_redirect_valid_d;
      redirect_pc_o      <= w_redirect_pc_d;
      intrrupt_ack2clint <= w_ack_d;
    end
  end

  // Stall is combinational in IDLE so the trapping instruction never commits.
  assign ex_stall_o = !rrst && (((r_state == StIdle) && w_event) || (r_state == StSave));

endmodule

// File: tb/tb_ysyx_22040632_trap_ctrl.sv
// Directed self-checking bench for ysyx_22040632_trap_ctrl.
module tb_ysyx_22040632_trap_ctrl;

  logic        clk;
  logic        rrst;
  logic        irq;
  logic        ack;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ecall;
  logic        mret;
  logic        stall;
  logic [63:0] mstatus;
  logic [63:0] mepc;
  logic [63:0] mtvec;
  logic        we_mepc, we_mcause, we_mstatus;
  logic [63:0] o_mepc, o_mcause, o_mstatus;
  logic        flush;
  logic        rd_valid;
  logic [63:0] rd_pc;

  int tests;
  int fails;

  ysyx_22040632_trap_ctrl #(
    .XLEN        (64),
    .TIMER_CAUSE (7),
    .ECALL_CAUSE (11)
  ) dut (
    .clk                (clk),
    .rrst               (rrst),
    .intrrupt_timing2ex (irq),
    .intrrupt_ack2clint (ack),
    .ex_valid_i         (ex_valid),
    .ex_pc_i            (ex_pc),
    .ex_ecall_i         (ecall),
    .ex_mret_i          (mret),
    .ex_stall_o         (stall),
    .mstatus_i          (mstatus),
    .mepc_i             (mepc),
    .mtvec_i            (mtvec),
    .csr_we_mepc_o      (we_mepc),
    .csr_we_mcause_o    (we_mcause),
    .csr_we_mstatus_o   (we_mstatus),
    .csr_mepc_o         (o_mepc),
    .csr_mcause_o       (o_mcause),
    .csr_mstatus_o      (o_mstatus),
    .flush_o            (flush),
    .redirect_valid_o   (rd_valid),
    .redirect_pc_o      (rd_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    irq      = 1'b0;
    ecall    = 1'b0;
    mret     = 1'b0;
    ex_valid = 1'b0;
  endtask

  // Runs one trap from the event cycle through the return to IDLE.
  task automatic run_trap(input string tag, input logic e_we_mepc, input logic e_we_mcause,
                          input logic [63:0] e_mepc, input logic [63:0] e_mcause,
                          input logic [63:0] e_mstatus, input logic [63:0] e_pc,
                          input logic e_ack);
    #1;
    chk({tag, ".stall_n"}, 64'(stall), 64'd1);
    step();
    clear_ev();
    chk({tag, ".stall_save"}, 64'(stall), 64'd1);
    chk({tag, ".we_mepc"}, 64'(we_mepc), 64'(e_we_mepc));
    chk({tag, ".we_mcause"}, 64'(we_mcause), 64'(e_we_mcause));
    chk({tag, ".we_mstatus"}, 64'(we_mstatus), 64'd1);
    if (e_we_mepc) chk({tag, ".mepc"}, o_mepc, e_mepc);
    if (e_we_mcause) chk({tag, ".mcause"}, o_mcause, e_mcause);
    chk({tag, ".mstatus"}, o_mstatus, e_mstatus);
    chk({tag, ".flush_save"}, 64'(flush), 64'd0);
    chk({tag, ".ack_save"}, 64'(ack), 64'd0);
    step();
    chk({tag, ".flush"}, 64'(flush), 64'd1);
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".rd_pc"}, rd_pc, e_pc);
    chk({tag, ".ack"}, 64'(ack), 64'(e_ack));
    chk({tag, ".stall_jump"}, 64'(stall), 64'd0);
    chk({tag, ".we_jump"}, 64'({we_mepc, we_mcause, we_mstatus}), 64'd0);
    step();
    chk({tag, ".idle_pulses"}, 64'({flush, rd_valid, ack, we_mstatus}), 64'd0);
  endtask

  initial begin
    logic [63:0] vec_pc;
    tests = 0;
    fails = 0;
    rrst = 1'b1;
    clear_ev();
    ex_pc   = '0;
    mstatus = '0;
    mepc    = '0;
    mtvec   = '0;
    #2;
    chk("rst.outs", 64'({ack, stall, we_mepc, we_mcause, we_mstatus, flush, rd_valid}), 64'd0);
    chk("rst.rd_pc", rd_pc, 64'd0);
    chk("rst.mcause", o_mcause, 64'd0);
    step();
    step();
    rrst = 1'b0;
    step();

    // Timer interrupt.
    irq = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0100;
    mtvec = 64'h8000_0000; mstatus = 64'h8;
    run_trap("irq", 1'b1, 1'b1, 64'h8000_0100, 64'h8000_0000_0000_0007, 64'h1880,
             64'h8000_0000, 1'b1);

    // Interrupt held high while EX is empty: no trap.
    irq = 1'b1; ex_valid = 1'b0;
    #1;
    chk("novalid.stall", 64'(stall), 64'd0);
    step();
    chk("novalid.we", 64'({we_mepc, we_mcause, we_mstatus}), 64'd0);
    clear_ev();

    // ecall, no interrupt.
    ecall = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0200; mstatus = 64'h8;
    run_trap("ecall", 1'b1, 1'b1, 64'h8000_0200, 64'd11, 64'h1880, 64'h8000_0000, 1'b0);

    // Interrupt and ecall together: interrupt wins.
    irq = 1'b1; ecall = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0300; mstatus = 64'h0;
    run_trap("irq_ecall", 1'b1, 1'b1, 64'h8000_0300, 64'h8000_0000_0000_0007, 64'h1800,
             64'h8000_0000, 1'b1);

    // mret.
    mret = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0400;
    mstatus = 64'h1880; mepc = 64'h8000_0104;
    run_trap("mret", 1'b0, 1'b0, 64'd0, 64'd0, 64'h1888, 64'h8000_0104, 1'b0);

    // Reset during SAVE drops the trap.
    irq = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0500; mstatus = 64'h8;
    step();
    chk("rstsave.in_save", 64'(we_mstatus), 64'd1);
    rrst = 1'b1;
    #1;
    chk("rstsave.outs", 64'({ack, stall, we_mepc, we_mcause, we_mstatus, flush, rd_valid}),
        64'd0);
    chk("rstsave.mepc", o_mepc, 64'd0);
    clear_ev();
    step();
    rrst = 1'b0;
    step();
    chk("rstsave.no_redirect", 64'({rd_valid, flush, ack}), 64'd0);
    step();
    chk("rstsave.no_redirect2", 64'({rd_valid, flush, ack}), 64'd0);

    // Interrupt after reset is handled normally; deassert right after capture.
    irq = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0600; mstatus = 64'h8;
    run_trap("irq2", 1'b1, 1'b1, 64'h8000_0600, 64'h8000_0000_0000_0007, 64'h1880,
             64'h8000_0000, 1'b1);

    // Vectored mtvec: timer goes to base+0x1C only when the feature is built in.
`ifdef YSYX_22040632_VECTORED_MTVEC_EN
    vec_pc = 64'h8000_001C;
`else
    vec_pc = 64'h8000_0000;
`endif
    mtvec = 64'h8000_0001;
    irq = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0700; mstatus = 64'h8;
    run_trap("vec_irq", 1'b1, 1'b1, 64'h8000_0700, 64'h8000_0000_0000_0007, 64'h1880,
             vec_pc, 1'b1);
    ecall = 1'b1; ex_valid = 1'b1; ex_pc = 64'h8000_0800; mstatus = 64'h8;
    run_trap("vec_ecall", 1'b1, 1'b1, 64'h8000_0800, 64'd11, 64'h1880, 64'h8000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
